// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// Boot loader for the RISC_SPM memory. Holds the CPU in reset, optionally
// zero-fills the whole SRAM, then streams program words from a valid/ready
// port into consecutive SRAM addresses starting at BASE_ADDR. Once the final
// word has been written the CPU is released.
//
// Optional feature macro: LOADER_CLEAR_EN
//   defined   : a start first walks every SRAM address writing zero (CLEAR),
//               then moves on to LOAD.
//   undefined : start goes straight to LOAD; untouched words keep contents.
//
// Every output is a register. A word accepted in cycle N appears on the SRAM
// write port in cycle N+1. The FLUSH state exists so that the last write of
// an image (or of an overflowing image) is issued while the loader is still
// busy, and done/err only rise once the write port has gone quiet.
// ---------------------------------------------------------------------------
module prog_loader #(
   parameter int WORD_SIZE = 8,
   parameter int ADDR_SIZE = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic [WORD_SIZE-1:0] in_data,
   input  logic                 in_last,
   output logic                 in_ready,
   output logic                 mem_we,
   output logic [ADDR_SIZE-1:0] mem_addr,
   output logic [WORD_SIZE-1:0] mem_wdata,
   output logic                 cpu_hold,
   output logic                 done,
   output logic                 err,
   output logic [ADDR_SIZE:0]   word_count
);

   // Extended-width constants so address arithmetic never silently wraps.
   localparam logic [ADDR_SIZE:0] BASE_EXT = (ADDR_SIZE+1)'(BASE_ADDR);
   localparam logic [ADDR_SIZE:0] TOP_EXT  = {1'b0, {ADDR_SIZE{1'b1}}};
   localparam logic [ADDR_SIZE-1:0] TOP_ADDR = {ADDR_SIZE{1'b1}};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      LOAD  = 3'd2,
      FLUSH = 3'd3,
      DONE  = 3'd4,
      ERROR = 3'd5
   } state_t;

   state_t                 state;
   logic                   finish_ok;
   logic [ADDR_SIZE:0]     accept_addr;
   logic                   accept;

   // Address the currently offered word would land at, one bit wider than
   // the SRAM so the top-of-memory test is exact.
   always_comb begin
      accept_addr = BASE_EXT + word_count;
      accept      = in_valid & in_ready;
   end

   // Loader sequencer: state, SRAM write port, handshake and status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         finish_ok  <= 1'b0;
         in_ready   <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cpu_hold   <= 1'b1;
         done       <= 1'b0;
         err        <= 1'b0;
         word_count <= '0;
      end else begin
         case (state)
            IDLE, DONE, ERROR: begin
               mem_we <= 1'b0;
               if (start) begin
                  word_count <= '0;
                  done       <= 1'b0;
                  err        <= 1'b0;
                  cpu_hold   <= 1'b1;
                  finish_ok  <= 1'b0;
`ifdef LOADER_CLEAR_EN
                  state      <= CLEAR;
                  in_ready   <= 1'b0;
                  mem_we     <= 1'b1;
                  mem_addr   <= '0;
                  mem_wdata  <= '0;
`else
                  state      <= LOAD;
                  in_ready   <= 1'b1;
`endif
               end
            end

            CLEAR: begin
               if (mem_addr == TOP_ADDR) begin
                  mem_we   <= 1'b0;
                  in_ready <= 1'b1;
                  state    <= LOAD;
               end else begin
                  mem_we   <= 1'b1;
                  mem_addr <= mem_addr + 1'b1;
               end
            end

            LOAD: begin
               mem_we <= 1'b0;
               if (accept) begin
                  mem_we     <= 1'b1;
                  mem_addr   <= accept_addr[ADDR_SIZE-1:0];
                  mem_wdata  <= in_data;
                  word_count <= word_count + 1'b1;
                  if (in_last) begin
                     state     <= FLUSH;
                     in_ready  <= 1'b0;
                     finish_ok <= 1'b1;
                  end else if (accept_addr == TOP_EXT) begin
                     state     <= FLUSH;
                     in_ready  <= 1'b0;
                     finish_ok <= 1'b0;
                  end
               end
            end

            FLUSH: begin
               mem_we <= 1'b0;
               if (finish_ok) begin
                  state    <= DONE;
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
               end else begin
                  state    <= ERROR;
                  err      <= 1'b1;
               end
            end

            default: begin
               state    <= IDLE;
               mem_we   <= 1'b0;
               in_ready <= 1'b0;
               cpu_hold <= 1'b1;
               done     <= 1'b0;
               err      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
// Two loaders share one stream: instance a with BASE_ADDR=0 and instance b
// with BASE_ADDR=252 (near the top of a 256-word SRAM). Inputs change on the
// falling edge and outputs are sampled on the following falling edge, one
// rising edge later. Honours LOADER_CLEAR_EN the same way the design does.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_prog_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_last;

   logic       a_in_ready, a_mem_we, a_cpu_hold, a_done, a_err;
   logic [7:0] a_mem_addr, a_mem_wdata;
   logic [8:0] a_word_count;
   logic       b_in_ready, b_mem_we, b_cpu_hold, b_done, b_err;
   logic [7:0] b_mem_addr, b_mem_wdata;
   logic [8:0] b_word_count;

   int n_cmp = 0;
   int n_fail = 0;

   logic [7:0] mem_a [256];
   logic [7:0] mem_b [256];
   logic       b_low_write;

   prog_loader #(.WORD_SIZE(8), .ADDR_SIZE(8), .BASE_ADDR(0)) dut_a (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(a_in_ready), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .cpu_hold(a_cpu_hold), .done(a_done), .err(a_err),
      .word_count(a_word_count));

   prog_loader #(.WORD_SIZE(8), .ADDR_SIZE(8), .BASE_ADDR(252)) dut_b (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(b_in_ready), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .cpu_hold(b_cpu_hold), .done(b_done), .err(b_err),
      .word_count(b_word_count));

   // Free-running clock, 10 ns period.
   always #5 clk = ~clk;

   // SRAM models capture every write strobe; b also flags writes below its base.
   always @(posedge clk) begin
      if (a_mem_we) mem_a[a_mem_addr] = a_mem_wdata;
      if (b_mem_we) begin
         mem_b[b_mem_addr] = b_mem_wdata;
         if (b_mem_addr < 8'd252) b_low_write = 1'b1;
      end
   end

   // Present one stream beat and advance to the next falling edge.
   task automatic step(input logic v, input logic [7:0] d, input logic l);
      in_valid = v;
      in_data  = d;
      in_last  = l;
      @(negedge clk);
   endtask

   // Pulse start and wait until the loaders sit in LOAD.
   task automatic do_start();
      in_valid = 1'b0;
      in_last  = 1'b0;
      start    = 1'b1;
      @(negedge clk);
      start    = 1'b0;
`ifdef LOADER_CLEAR_EN
      repeat (256) @(negedge clk);
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
      b_low_write = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (a_cpu_hold !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_cpu_hold got %b want 1", a_cpu_hold); end
      n_cmp++; if ({a_in_ready, a_mem_we, a_done, a_err} !== 4'b0000) begin n_fail++; $display("[TB] FAIL rst_flags got %b want 0000", {a_in_ready, a_mem_we, a_done, a_err}); end
      n_cmp++; if ({a_mem_addr, a_mem_wdata, a_word_count} !== 25'd0) begin n_fail++; $display("[TB] FAIL rst_regs got %h want 0", {a_mem_addr, a_mem_wdata, a_word_count}); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_clear();
`ifdef LOADER_CLEAR_EN
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 256; i++) begin
         n_cmp++; if ({a_mem_we, a_in_ready} !== 2'b10 || a_mem_addr !== 8'(i) || a_mem_wdata !== 8'h00) begin
            n_fail++; $display("[TB] FAIL clear_write got we=%b rdy=%b addr=%h data=%h want we=1 rdy=0 addr=%h data=00", a_mem_we, a_in_ready, a_mem_addr, a_mem_wdata, 8'(i));
         end
         @(negedge clk);
      end
      n_cmp++; if ({a_in_ready, a_mem_we} !== 2'b10) begin n_fail++; $display("[TB] FAIL clear_to_load got rdy=%b we=%b want rdy=1 we=0", a_in_ready, a_mem_we); end
      n_cmp++; if (mem_a[255] !== 8'h00) begin n_fail++; $display("[TB] FAIL clear_top_word got %h want 00", mem_a[255]); end
      step(1'b1, 8'h77, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      step(1'b0, 8'h00, 1'b0);
`else
      n_cmp++; if (mem_a[255] !== 8'hFF) begin n_fail++; $display("[TB] FAIL untouched_word got %h want FF", mem_a[255]); end
`endif
   endtask

   task automatic test_mid_load_reset();
      do_start();
      step(1'b1, 8'h11, 1'b0);
      step(1'b1, 8'h22, 1'b0);
      step(1'b1, 8'h33, 1'b0);
      n_cmp++; if (a_word_count !== 9'd3) begin n_fail++; $display("[TB] FAIL pre_reset_count got %0d want 3", a_word_count); end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if ({a_cpu_hold, a_mem_we, a_in_ready} !== 3'b100) begin n_fail++; $display("[TB] FAIL midreset_flags got %b want 100", {a_cpu_hold, a_mem_we, a_in_ready}); end
      n_cmp++; if (a_word_count !== 9'd0) begin n_fail++; $display("[TB] FAIL midreset_count got %0d want 0", a_word_count); end
      rst = 1'b0;
      step(1'b1, 8'h44, 1'b0);
      n_cmp++; if ({a_mem_we, a_in_ready} !== 2'b00) begin n_fail++; $display("[TB] FAIL idle_ignores_valid got we=%b rdy=%b want 0 0", a_mem_we, a_in_ready); end
      step(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_load();
      logic [7:0] prog [9];
      prog = '{8'h00, 8'hA0, 8'h45, 8'hA1, 8'h59, 8'hA2, 8'h4F, 8'hA3, 8'h63};
      do_start();
      n_cmp++; if ({a_in_ready, a_cpu_hold, a_done} !== 3'b110) begin n_fail++; $display("[TB] FAIL load_entry got %b want 110", {a_in_ready, a_cpu_hold, a_done}); end
      for (int i = 0; i < 9; i++) begin
         step(1'b1, prog[i], i == 8);
         n_cmp++; if (a_mem_we !== 1'b1 || a_mem_addr !== 8'(i) || a_mem_wdata !== prog[i]) begin
            n_fail++; $display("[TB] FAIL load_write got we=%b addr=%h data=%h want we=1 addr=%h data=%h", a_mem_we, a_mem_addr, a_mem_wdata, 8'(i), prog[i]);
         end
         n_cmp++; if (a_in_ready !== (i != 8) || a_word_count !== 9'(i + 1)) begin
            n_fail++; $display("[TB] FAIL load_status got rdy=%b cnt=%0d want rdy=%b cnt=%0d", a_in_ready, a_word_count, i != 8, i + 1);
         end
      end
      step(1'b0, 8'h00, 1'b0);
      n_cmp++; if ({a_done, a_cpu_hold, a_mem_we, a_err} !== 4'b1000) begin n_fail++; $display("[TB] FAIL load_done got %b want 1000", {a_done, a_cpu_hold, a_mem_we, a_err}); end
      n_cmp++; if (a_mem_addr !== 8'h08 || a_mem_wdata !== 8'h63) begin n_fail++; $display("[TB] FAIL load_hold got addr=%h data=%h want 08 63", a_mem_addr, a_mem_wdata); end
      for (int i = 0; i < 9; i++) begin
         n_cmp++; if (mem_a[i] !== prog[i]) begin n_fail++; $display("[TB] FAIL load_mem got %h want %h at %0d", mem_a[i], prog[i], i); end
      end
   endtask

   task automatic test_overflow();
      do_start();
      b_low_write = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 8'hC0 + 8'(i), 1'b0);
         if (i < 4) begin
            n_cmp++; if (b_mem_we !== 1'b1 || b_mem_addr !== 8'(252 + i) || b_mem_wdata !== 8'hC0 + 8'(i)) begin
               n_fail++; $display("[TB] FAIL ovf_write got we=%b addr=%h data=%h want we=1 addr=%h data=%h", b_mem_we, b_mem_addr, b_mem_wdata, 8'(252 + i), 8'hC0 + 8'(i));
            end
         end
      end
      n_cmp++; if ({b_mem_we, b_err, b_cpu_hold, b_done, b_in_ready} !== 5'b01100) begin n_fail++; $display("[TB] FAIL ovf_error got %b want 01100", {b_mem_we, b_err, b_cpu_hold, b_done, b_in_ready}); end
      n_cmp++; if (b_word_count !== 9'd4 || b_mem_addr !== 8'hFF) begin n_fail++; $display("[TB] FAIL ovf_count got cnt=%0d addr=%h want 4 FF", b_word_count, b_mem_addr); end
      step(1'b1, 8'hC5, 1'b1);
      step(1'b0, 8'h00, 1'b0);
      n_cmp++; if (b_err !== 1'b1 || b_low_write !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_nowrap got err=%b low=%b want 1 0", b_err, b_low_write); end
      n_cmp++; if (a_done !== 1'b1 || mem_a[5] !== 8'hC5) begin n_fail++; $display("[TB] FAIL ovf_other got done=%b m5=%h want 1 C5", a_done, mem_a[5]); end
   endtask

   task automatic test_exact_fit();
      do_start();
      b_low_write = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b1, 8'hD0 + 8'(i), i == 3);
      n_cmp++; if (b_mem_we !== 1'b1 || b_mem_addr !== 8'hFF || b_mem_wdata !== 8'hD3) begin n_fail++; $display("[TB] FAIL fit_write got we=%b addr=%h data=%h want 1 FF D3", b_mem_we, b_mem_addr, b_mem_wdata); end
      step(1'b0, 8'h00, 1'b0);
      n_cmp++; if ({b_done, b_err, b_cpu_hold} !== 3'b100) begin n_fail++; $display("[TB] FAIL fit_done got %b want 100", {b_done, b_err, b_cpu_hold}); end
      n_cmp++; if (mem_b[252] !== 8'hD0 || mem_b[255] !== 8'hD3 || b_low_write !== 1'b0) begin n_fail++; $display("[TB] FAIL fit_mem got %h %h low=%b want D0 D3 0", mem_b[252], mem_b[255], b_low_write); end
   endtask

   task automatic test_gaps_and_reload();
      logic [7:0] vals [4];
      vals = '{8'h11, 8'h22, 8'h33, 8'h44};
      do_start();
      for (int i = 0; i < 7; i++) begin
         if (i == 3) start = 1'b1;
         step(i % 2 == 0, vals[i / 2], i == 6);
         start = 1'b0;
         if (i % 2 == 0) begin
            n_cmp++; if (a_mem_we !== 1'b1 || a_mem_addr !== 8'(i / 2) || a_mem_wdata !== vals[i / 2]) begin
               n_fail++; $display("[TB] FAIL gap_write got we=%b addr=%h data=%h want 1 %h %h", a_mem_we, a_mem_addr, a_mem_wdata, 8'(i / 2), vals[i / 2]);
            end
         end else begin
            n_cmp++; if (a_mem_we !== 1'b0 || a_in_ready !== 1'b1 || a_mem_addr !== 8'(i / 2) || a_word_count !== 9'(i / 2 + 1)) begin
               n_fail++; $display("[TB] FAIL gap_idle got we=%b rdy=%b addr=%h cnt=%0d want 0 1 %h %0d", a_mem_we, a_in_ready, a_mem_addr, a_word_count, 8'(i / 2), i / 2 + 1);
            end
         end
      end
      step(1'b0, 8'h00, 1'b0);
      n_cmp++; if ({a_done, a_cpu_hold} !== 2'b10 || a_word_count !== 9'd4) begin n_fail++; $display("[TB] FAIL gap_done got %b cnt=%0d want 10 4", {a_done, a_cpu_hold}, a_word_count); end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++; if ({a_cpu_hold, a_done} !== 2'b10 || a_word_count !== 9'd0) begin n_fail++; $display("[TB] FAIL reload_entry got %b cnt=%0d want 10 0", {a_cpu_hold, a_done}, a_word_count); end
`ifdef LOADER_CLEAR_EN
      repeat (256) @(negedge clk);
`endif
      step(1'b1, 8'h5A, 1'b1);
      n_cmp++; if (a_mem_we !== 1'b1 || a_mem_addr !== 8'h00 || a_mem_wdata !== 8'h5A) begin n_fail++; $display("[TB] FAIL reload_write got we=%b addr=%h data=%h want 1 00 5A", a_mem_we, a_mem_addr, a_mem_wdata); end
      step(1'b0, 8'h00, 1'b0);
      n_cmp++; if ({a_done, a_cpu_hold} !== 2'b10 || a_word_count !== 9'd1) begin n_fail++; $display("[TB] FAIL reload_done got %b cnt=%0d want 10 1", {a_done, a_cpu_hold}, a_word_count); end
   endtask

   // Test sequence; the SRAM models start out filled with FF.
   initial begin
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 8'hFF;
         mem_b[i] = 8'hFF;
      end
      test_reset();
      test_clear();
      test_mid_load_reset();
      test_load();
      test_overflow();
      test_exact_fit();
      test_gaps_and_reload();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
